scope_capture_buffer: RTL and testbench

Triggered multi-channel sample capture buffer for the oscilloscope path. It replaces the free-running push shift register with a ring-buffer memory that records a configurable number of pre-trigger samples, waits for a level/edge trigger on a selected channel, and fills the post-trigger samples. It then freezes the frame so the VGA renderer reads a stable capture by column index. It sits between the ADC front end and the pixel mapping stage.

---
 rtl/scope_pkg.sv | 28 ++
 rtl/scope_trigger_detect.sv | 91 +++++++++
 rtl/scope_capture_buffer.sv | 163 ++++++++++++++++
 tb/tb_scope_capture_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and helpers for the triggered scope capture buffer.
package scope_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POST,
    DONE
  } state_e;

  typedef enum logic {
    EDGE_RISING  = 1'b0,
    EDGE_FALLING = 1'b1
  } edge_sel_e;

  // (a + b) mod depth for a < depth and b <= depth, without a divider,
  // so DEPTH does not have to be a power of two.
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned depth);
    int unsigned s;
    s = a + b;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/scope_trigger_detect.sv
// Trigger detector: selects the trigger channel, keeps the previous accepted
// sample, compares against the level for a rising/falling crossing and runs
// the auto-trigger timeout while armed.
module scope_trigger_detect
  import scope_pkg::*;
#(
  parameter int DATA_WIDTH   = 10,
  parameter int CHANNELS     = 2,
  parameter int AUTO_TIMEOUT = 65535,
  parameter int SRC_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_sample,
  input  logic                         i_accept,
  input  logic                         i_arm,
  input  logic                         i_armed,
  input  logic [SRC_W-1:0]             i_trig_src,
  input  logic [DATA_WIDTH-1:0]        i_trig_level,
  input  logic                         i_trig_falling,
  input  logic                         i_auto_en,
  output logic                         o_trig,
  output logic                         o_forced
);

  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  prev_valid_q, prev_valid_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  edge_sel_e             edge_sel;
  logic                  edge_hit;
  logic                  timeout_hit;

  assign edge_sel = edge_sel_e'(i_trig_falling);

  // Channel mux; out-of-range selects fall back to channel 0.
  always_comb begin
    cur = i_sample[0 +: DATA_WIDTH];
    for (int k = 1; k < CHANNELS; k++) begin
      if (32'(i_trig_src) == k) cur = i_sample[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Level crossing against the previous sample, plus the forced-trigger condition.
  always_comb begin
    edge_hit = 1'b0;
    if (prev_valid_q) begin
      if (edge_sel == EDGE_RISING)
        edge_hit = (prev_q < i_trig_level) && (cur >= i_trig_level);
      else
        edge_hit = (prev_q > i_trig_level) && (cur <= i_trig_level);
    end
    timeout_hit = i_auto_en && (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));
    o_trig      = i_accept && i_armed && (edge_hit || timeout_hit);
    o_forced    = o_trig && !edge_hit;
  end

  // Next-state for the history and timeout; arm starts a fresh history.
  always_comb begin
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    to_cnt_d     = to_cnt_q;
    if (i_arm) begin
      prev_valid_d = 1'b0;
      to_cnt_d     = '0;
    end else if (i_accept) begin
      prev_d       = cur;
      prev_valid_d = 1'b1;
      if (i_armed && i_auto_en) to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Control state: validity flag and timeout counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_valid_q <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      prev_valid_q <= prev_valid_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  // Previous sample value; only meaningful while prev_valid_q is set.
  always_ff @(posedge i_clk) begin
    prev_q <= prev_d;
  end

endmodule

// File: rtl/scope_capture_buffer.sv
// Triggered multi-channel capture buffer: ring memory with pre-trigger
// history, edge/auto trigger, post-trigger fill and a frozen frame read
// out by column index (0 = oldest sample).
module scope_capture_buffer
  import scope_pkg::*;
#(
  parameter int DATA_WIDTH   = 10,
  parameter int DEPTH        = 640,
  parameter int CHANNELS     = 2,
  parameter int AUTO_TIMEOUT = 65535,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int SRC_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_sample_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_sample,
  input  logic                           i_arm,
  input  logic [SRC_W-1:0]               i_trig_src,
  input  logic [DATA_WIDTH-1:0]          i_trig_level,
  input  logic                           i_trig_falling,
  input  logic                           i_auto_en,
  input  logic [ADDR_WIDTH-1:0]          i_pretrig,
  input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_rd_data,
  output logic                           o_busy,
  output logic                           o_frame_valid,
  output logic                           o_trig_forced
);

  localparam int SW = CHANNELS * DATA_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] post_q, post_d;
  logic [ADDR_WIDTH-1:0] pretrig_q, pretrig_d;
  logic [ADDR_WIDTH-1:0] trig_ptr_q, trig_ptr_d;
  logic                  forced_q, forced_d;
  logic [SW-1:0]         rd_data_q;

  logic [SW-1:0]         mem [DEPTH];

  logic                  accept;
  logic                  trig;
  logic                  trig_forced;
  logic [ADDR_WIDTH-1:0] arm_pretrig;
  logic [ADDR_WIDTH-1:0] post_target;
  int unsigned           rd_base;
  logic [ADDR_WIDTH-1:0] rd_phys;

  assign o_busy        = (state_q == PRETRIG) || (state_q == ARMED) || (state_q == POST);
  assign o_frame_valid = (state_q == DONE);
  assign o_trig_forced = forced_q;
  assign o_rd_data     = rd_data_q;

  // Arm wins over a coincident sample, so that sample is never written.
  assign accept      = i_sample_valid && !i_arm && o_busy;
  assign arm_pretrig = (32'(i_pretrig) > 32'(DEPTH - 1)) ? ADDR_WIDTH'(DEPTH - 1) : i_pretrig;
  assign post_target = ADDR_WIDTH'(DEPTH - 1) - pretrig_q;

  scope_trigger_detect #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CHANNELS    (CHANNELS),
    .AUTO_TIMEOUT(AUTO_TIMEOUT),
    .SRC_W       (SRC_W)
  ) u_trig (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_sample      (i_sample),
    .i_accept      (accept),
    .i_arm         (i_arm),
    .i_armed       (state_q == ARMED),
    .i_trig_src    (i_trig_src),
    .i_trig_level  (i_trig_level),
    .i_trig_falling(i_trig_falling),
    .i_auto_en     (i_auto_en),
    .o_trig        (trig),
    .o_forced      (trig_forced)
  );

  // Capture FSM next-state: arm restarts from any state, samples advance the fill.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    fill_d     = fill_q;
    post_d     = post_q;
    pretrig_d  = pretrig_q;
    trig_ptr_d = trig_ptr_q;
    forced_d   = forced_q;
    if (i_arm) begin
      pretrig_d = arm_pretrig;
      fill_d    = '0;
      post_d    = '0;
      forced_d  = 1'b0;
      state_d   = (arm_pretrig == '0) ? ARMED : PRETRIG;
    end else if (accept) begin
      unique case (state_q)
        PRETRIG: begin
          fill_d = fill_q + ADDR_WIDTH'(1);
          if (fill_q + ADDR_WIDTH'(1) == pretrig_q) state_d = ARMED;
        end
        ARMED: begin
          if (trig) begin
            trig_ptr_d = wptr_q;
            forced_d   = trig_forced;
            state_d    = (post_target == '0) ? DONE : POST;
          end
        end
        POST: begin
          post_d = post_q + ADDR_WIDTH'(1);
          if (post_q + ADDR_WIDTH'(1) == post_target) state_d = DONE;
        end
        default: ;
      endcase
      wptr_d = (wptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wptr_q + ADDR_WIDTH'(1);
    end
  end

  // Capture FSM and pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      fill_q     <= '0;
      post_q     <= '0;
      pretrig_q  <= '0;
      trig_ptr_q <= '0;
      forced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      post_q     <= post_d;
      pretrig_q  <= pretrig_d;
      trig_ptr_q <= trig_ptr_d;
      forced_q   <= forced_d;
    end
  end

  // Ring memory write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (accept) mem[wptr_q] <= i_sample;
  end

  // Frame index to physical slot: oldest sample sits pretrig_q slots before the trigger.
  always_comb begin
    rd_base = wrap_add(32'(trig_ptr_q), 32'(DEPTH) - 32'(pretrig_q), 32'(DEPTH));
    rd_phys = ADDR_WIDTH'(wrap_add(rd_base, 32'(i_rd_addr), 32'(DEPTH)));
  end

  // Registered read port; indices past the frame read as zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_q <= '0;
    end else if (32'(i_rd_addr) >= 32'(DEPTH)) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_phys];
    end
  end

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Directed bench for scope_capture_buffer with DEPTH=8, two 10-bit channels
// and a short auto timeout.
module tb_scope_capture_buffer;

  localparam int DW = 10;
  localparam int DEPTH = 8;
  localparam int CH = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_valid;
  logic [CH*DW-1:0] sample;
  logic          arm;
  logic [0:0]    trig_src;
  logic [DW-1:0] trig_level;
  logic          trig_falling;
  logic          auto_en;
  logic [AW-1:0] pretrig;
  logic [AW-1:0] rd_addr;
  logic [CH*DW-1:0] rd_data;
  logic          busy;
  logic          frame_valid;
  logic          trig_forced;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scope_capture_buffer #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .CHANNELS    (CH),
    .AUTO_TIMEOUT(4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sample_valid(sample_valid),
    .i_sample      (sample),
    .i_arm         (arm),
    .i_trig_src    (trig_src),
    .i_trig_level  (trig_level),
    .i_trig_falling(trig_falling),
    .i_auto_en     (auto_en),
    .i_pretrig     (pretrig),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_busy        (busy),
    .o_frame_valid (frame_valid),
    .o_trig_forced (trig_forced)
  );

  typedef struct {
    int pretrig;
    int src;
    int level;
    bit falling;
    bit auto_en;
    int n;
    int s0[12];
    int s1[12];
    int e0[8];
    int e1[8];
    bit forced;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c0, input int c1);
    sample_valid = 1'b1;
    sample = {c1[DW-1:0], c0[DW-1:0]};
    step();
    sample_valid = 1'b0;
  endtask

  task automatic arm_cap(input int pre, input int src, input int lvl, input bit fall, input bit aut);
    pretrig      = pre[AW-1:0];
    trig_src     = src[0:0];
    trig_level   = lvl[DW-1:0];
    trig_falling = fall;
    auto_en      = aut;
    arm          = 1'b1;
    step();
    arm          = 1'b0;
  endtask

  task automatic rd(input int idx, output int c0, output int c1);
    rd_addr = idx[AW-1:0];
    step();
    c0 = int'(rd_data[DW-1:0]);
    c1 = int'(rd_data[2*DW-1:DW]);
  endtask

  initial begin
    int r0, r1;

    rst = 1'b1; sample_valid = 1'b0; sample = '0; arm = 1'b0; trig_src = '0;
    trig_level = '0; trig_falling = 1'b0; auto_en = 1'b0; pretrig = '0; rd_addr = '0;

    // Rising edge, normal frame
    vecs[0].pretrig = 3; vecs[0].src = 0; vecs[0].level = 512; vecs[0].falling = 0;
    vecs[0].auto_en = 0; vecs[0].n = 9; vecs[0].forced = 0;
    vecs[0].s0 = '{100, 200, 300, 400, 600, 700, 800, 900, 1000, 0, 0, 0};
    vecs[0].s1 = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 0, 0, 0};
    vecs[0].e0 = '{200, 300, 400, 600, 700, 800, 900, 1000};
    vecs[0].e1 = '{12, 13, 14, 15, 16, 17, 18, 19};
    // Edge inside pre-trigger fill must be ignored
    vecs[1].pretrig = 3; vecs[1].src = 0; vecs[1].level = 512; vecs[1].falling = 0;
    vecs[1].auto_en = 0; vecs[1].n = 9; vecs[1].forced = 0;
    vecs[1].s0 = '{400, 600, 700, 100, 600, 650, 700, 750, 800, 0, 0, 0};
    vecs[1].s1 = '{21, 22, 23, 24, 25, 26, 27, 28, 29, 0, 0, 0};
    vecs[1].e0 = '{600, 700, 100, 600, 650, 700, 750, 800};
    vecs[1].e1 = '{22, 23, 24, 25, 26, 27, 28, 29};
    // Falling edge on channel 1
    vecs[2].pretrig = 2; vecs[2].src = 1; vecs[2].level = 300; vecs[2].falling = 1;
    vecs[2].auto_en = 0; vecs[2].n = 8; vecs[2].forced = 0;
    vecs[2].s0 = '{31, 32, 33, 34, 35, 36, 37, 38, 0, 0, 0, 0};
    vecs[2].s1 = '{500, 400, 300, 250, 200, 150, 100, 50, 0, 0, 0, 0};
    vecs[2].e0 = '{31, 32, 33, 34, 35, 36, 37, 38};
    vecs[2].e1 = '{500, 400, 300, 250, 200, 150, 100, 50};
    // Auto timeout on a flat signal
    vecs[3].pretrig = 0; vecs[3].src = 0; vecs[3].level = 512; vecs[3].falling = 0;
    vecs[3].auto_en = 1; vecs[3].n = 11; vecs[3].forced = 1;
    vecs[3].s0 = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 0};
    vecs[3].s1 = '{41, 42, 43, 44, 45, 46, 47, 48, 49, 50, 51, 0};
    vecs[3].e0 = '{100, 100, 100, 100, 100, 100, 100, 100};
    vecs[3].e1 = '{44, 45, 46, 47, 48, 49, 50, 51};
    // Maximum pre-trigger: DONE directly after the trigger sample
    vecs[4].pretrig = 7; vecs[4].src = 0; vecs[4].level = 512; vecs[4].falling = 0;
    vecs[4].auto_en = 0; vecs[4].n = 9; vecs[4].forced = 0;
    vecs[4].s0 = '{10, 20, 30, 40, 50, 60, 70, 80, 600, 0, 0, 0};
    vecs[4].s1 = '{61, 62, 63, 64, 65, 66, 67, 68, 69, 0, 0, 0};
    vecs[4].e0 = '{20, 30, 40, 50, 60, 70, 80, 600};
    vecs[4].e1 = '{62, 63, 64, 65, 66, 67, 68, 69};

    // Reset state
    step(); step();
    chk("reset busy", int'(busy), 0);
    chk("reset frame_valid", int'(frame_valid), 0);
    chk("reset trig_forced", int'(trig_forced), 0);
    chk("reset rd_data", int'(rd_data), 0);
    rst = 1'b0;
    step();
    send(700, 700);
    chk("idle ignores samples busy", int'(busy), 0);
    chk("idle ignores samples frame_valid", int'(frame_valid), 0);

    // Table-driven frames, captured back to back so the write pointer wraps
    for (int t = 0; t < 5; t++) begin
      arm_cap(vecs[t].pretrig, vecs[t].src, vecs[t].level, vecs[t].falling, vecs[t].auto_en);
      chk($sformatf("v%0d busy after arm", t), int'(busy), 1);
      for (int i = 0; i < vecs[t].n; i++) begin
        if (i == vecs[t].n - 1) begin
          chk($sformatf("v%0d frame_valid before last", t), int'(frame_valid), 0);
          chk($sformatf("v%0d busy before last", t), int'(busy), 1);
        end
        send(vecs[t].s0[i], vecs[t].s1[i]);
        if (i % 3 == 1 && i != vecs[t].n - 1) step();
      end
      chk($sformatf("v%0d frame_valid", t), int'(frame_valid), 1);
      chk($sformatf("v%0d busy done", t), int'(busy), 0);
      chk($sformatf("v%0d trig_forced", t), int'(trig_forced), int'(vecs[t].forced));
      for (int i = 0; i < DEPTH; i++) begin
        rd(i, r0, r1);
        chk($sformatf("v%0d rd%0d ch0", t, i), r0, vecs[t].e0[i]);
        chk($sformatf("v%0d rd%0d ch1", t, i), r1, vecs[t].e1[i]);
      end
    end

    // Auto disabled: a flat signal never triggers
    arm_cap(0, 0, 512, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send(100, 100);
    chk("noauto busy", int'(busy), 1);
    chk("noauto frame_valid", int'(frame_valid), 0);

    // Restart while busy, then reset in POST
    arm_cap(0, 0, 512, 1'b0, 1'b0);
    chk("rearm busy", int'(busy), 1);
    send(100, 0);
    send(600, 0);
    send(100, 0);
    send(100, 0);
    chk("post busy", int'(busy), 1);
    chk("post frame_valid", int'(frame_valid), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst in post busy", int'(busy), 0);
    chk("rst in post frame_valid", int'(frame_valid), 0);
    for (int i = 0; i < 9; i++) send(600 + i, 0);
    chk("after rst busy", int'(busy), 0);
    chk("after rst frame_valid", int'(frame_valid), 0);

    // Arm/sample collision: the coincident sample must not count toward pre-fill
    pretrig = 3'd7; trig_src = 1'b0; trig_level = 10'd512; trig_falling = 1'b0; auto_en = 1'b0;
    arm = 1'b1; sample_valid = 1'b1; sample = {10'd0, 10'd100};
    step();
    arm = 1'b0; sample_valid = 1'b0;
    for (int i = 0; i < 6; i++) send(100, i);
    send(600, 6);
    chk("collision frame_valid", int'(frame_valid), 0);
    chk("collision busy", int'(busy), 1);
    send(100, 7);
    send(700, 8);
    chk("collision done frame_valid", int'(frame_valid), 1);
    rd(5, r0, r1);
    chk("collision rd5 ch0", r0, 600);
    rd(7, r0, r1);
    chk("collision rd7 ch0", r0, 700);
    chk("collision rd7 ch1", r1, 8);
    rd(0, r0, r1);
    chk("collision rd0 ch1", r1, 1);

    // Frozen frame ignores further samples
    send(999, 999);
    chk("frozen frame_valid", int'(frame_valid), 1);
    rd(7, r0, r1);
    chk("frozen rd7 ch0", r0, 700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
